// File: rtl/serial_frame_tx.sv
// Response-frame serializer: buffers payload bytes, then sends FF FF 00 len payload EE EE as UART characters.
// Define SERIAL_FRAME_TX_PARITY_EN for 8E1 characters; left undefined the link runs 8N1.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | accepting payload writes, waiting for send
// S_WAIT   | between characters, line high, waiting for rts
// S_START  | start bit (low)
// S_DATA   | eight data bits, LSB first
// S_PARITY | even parity bit (parity build only)
// S_STOP   | stop bit (high)
// S_GAP    | one idle bit time after each character
// S_DONE   | single-cycle frame-complete pulse
module serial_frame_tx #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int MAX_PAYLOAD = 16,
    localparam int CW = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          send,
    input  logic          rts,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] buf_count,
    output logic          wr_ovf
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(BIT_TICKS - 1);
    localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_DONE
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_idx;
    logic [8:0]    byte_idx;
    logic [CW-1:0] len;
    logic [7:0]    payload [MAX_PAYLOAD];
    logic [7:0]    cur_byte;
    logic          bit_done;
    logic          last_byte;
    logic          wr_accept;

    assign bit_done  = (tick_cnt == '0);
    assign last_byte = (byte_idx == 9'(len) + 9'd5);
    assign wr_accept = wr_en && (state == S_IDLE) && (buf_count < CW'(MAX_PAYLOAD));

    always_comb begin
        cur_byte = 8'hEE;
        if (byte_idx < 9'd2)
            cur_byte = 8'hFF;
        else if (byte_idx == 9'd2)
            cur_byte = 8'h00;
        else if (byte_idx == 9'd3)
            cur_byte = 8'(len);
        else if (byte_idx < 9'(len) + 9'd4)
            cur_byte = payload[IW'(byte_idx - 9'd4)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (send) next_state = S_WAIT;
            S_WAIT:   if (rts) next_state = S_START;
            S_START:  if (bit_done) next_state = S_DATA;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_DATA:   if (bit_done && bit_idx == 3'd7) next_state = S_PARITY;
            S_PARITY: if (bit_done) next_state = S_STOP;
`else
            S_DATA:   if (bit_done && bit_idx == 3'd7) next_state = S_STOP;
`endif
            S_STOP:   if (bit_done) next_state = S_GAP;
            S_GAP:    if (bit_done) next_state = last_byte ? S_DONE : S_WAIT;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // tx decodes straight from state so an async reset returns the line high at once.
    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            S_IDLE:   busy = 1'b0;
            S_START:  tx = 1'b0;
            S_DATA:   tx = cur_byte[bit_idx];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: tx = ^cur_byte;
`endif
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= TICK_MAX;
            bit_idx   <= '0;
            byte_idx  <= '0;
            len       <= '0;
            buf_count <= '0;
            wr_ovf    <= 1'b0;
        end else begin
            wr_ovf <= wr_en && !wr_accept;

            if (next_state == S_DONE)
                buf_count <= '0;
            else if (wr_accept)
                buf_count <= buf_count + CW'(1);

            // A write in the same cycle as send lands first and is counted.
            if (state == S_IDLE && send) begin
                len      <= wr_accept ? buf_count + CW'(1) : buf_count;
                byte_idx <= '0;
            end else if (state == S_GAP && bit_done) begin
                byte_idx <= byte_idx + 9'd1;
            end

            if (state == S_IDLE || state == S_WAIT || bit_done)
                tick_cnt <= TICK_MAX;
            else
                tick_cnt <= tick_cnt - TW'(1);

            if (state == S_START)
                bit_idx <= '0;
            else if (state == S_DATA && bit_done)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            payload[buf_count[IW-1:0]] <= wr_data;
    end

endmodule
